uart_rx: RTL and testbench

Serial receive half of the UART IO peripheral. The block oversamples the asynchronous `rxd` line at 16x the baud rate and deframes 8N1 characters, LSB first. Each good byte is handed to the RX FIFO write port. It sits beside the UART transmitter inside the memory-mapped UART peripheral on the system bus, and reports framing and overrun errors as one-cycle pulses for the status logic.

---
 rtl/uart_rx_if.sv | 27 ++
 rtl/uart_rx.sv | 179 +++++++++++++++++
 tb/tb_uart_rx.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side signal bundle for uart_rx: serial line, FIFO write port,
// error pulses and a debug view of the receiver state.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rxd;
    logic                 rx_full;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 overrun_err;
    logic                 parity_err;
    logic                 busy;
    logic [2:0]           dbg_state;

    // rx_valid is a write strobe with no ready: the FIFO reports rx_full,
    // and a byte that completes while rx_full=1 becomes overrun_err instead.
    modport master (
        output rxd, rx_full,
        input  rx_data, rx_valid, frame_err, overrun_err, parity_err, busy, dbg_state
    );

    modport slave (
        input  rxd, rx_full,
        output rx_data, rx_valid, frame_err, overrun_err, parity_err, busy, dbg_state
    );
endinterface

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver, 8N1 LSB first, with framing/overrun pulses.
// Define UART_RX_PARITY_EN to add an even-parity bit and parity_err.
module uart_rx #(
    parameter int CLK_DIV   = 27,
    parameter int DATA_BITS = 8
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.slave  bus
);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic                 rxd_meta_q, rxd_s_q;
    logic [15:0]          div_q, div_d;
    logic [3:0]           os_q, os_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 oerr_q, oerr_d;
    logic                 perr_q, perr_d;
    logic                 tick;
    logic                 par_ok;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    assign par_ok = ((^shift_q) == par_q);
`else
    assign par_ok = 1'b1;
`endif

    // Tick counter is held at zero in IDLE so ticks align to the start edge.
    assign tick = (state_q != S_IDLE) && (div_q == 16'(CLK_DIV - 1));

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        os_d    = os_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        oerr_d  = 1'b0;
        perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q == S_IDLE) begin
            div_d = '0;
            os_d  = '0;
            bit_d = '0;
        end else if (tick) begin
            div_d = '0;
            os_d  = os_q + 4'd1;
        end else begin
            div_d = div_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (!rxd_s_q) state_d = S_START;
            end
            S_START: begin
                if (tick && os_q == 4'd7) begin
                    if (rxd_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        os_d    = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick && os_q == 4'd15) begin
                    shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        bit_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick && os_q == 4'd15) begin
                    par_d   = rxd_s_q;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Sampled mid-stop-bit, so a back-to-back start edge is not missed.
                if (tick && os_q == 4'd15) begin
                    if (!rxd_s_q) begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end else begin
                        state_d = S_IDLE;
                        if (!par_ok) begin
                            perr_d = 1'b1;
                        end else if (bus.rx_full) begin
                            oerr_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            data_d  = shift_q;
                        end
                    end
                end
            end
            S_BREAK: begin
                if (rxd_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            div_q      <= '0;
            os_q       <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            oerr_q     <= 1'b0;
            perr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rxd_meta_q <= bus.rxd;
            rxd_s_q    <= rxd_meta_q;
            div_q      <= div_d;
            os_q       <= os_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            oerr_q     <= oerr_d;
            perr_q     <= perr_d;
`ifdef UART_RX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign bus.rx_data     = data_q;
    assign bus.rx_valid    = valid_q;
    assign bus.frame_err   = ferr_q;
    assign bus.overrun_err = oerr_q;
    assign bus.parity_err  = perr_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at CLK_DIV=4: table of framed characters plus hand-written
// glitch, break, back-to-back and mid-frame reset sequences.
module tb_uart_rx;
    localparam int CLK_DIV    = 4;
    localparam int BIT_CLKS   = 16 * CLK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int W = 10;
    localparam logic [1:0] K_VALID = 2'd0;
    localparam logic [1:0] K_FRM   = 2'd1;
    localparam logic [1:0] K_OVR   = 2'd2;
    localparam logic [1:0] K_PAR   = 2'd3;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_BREAK = 3'd5;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       full;
        logic       flip;
        logic [1:0] kind;
        logic [7:0] exp_data;
    } vec_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    int   prev_valid_cyc;
    int   last_valid_cyc;
    logic [7:0] last_good;
    logic [W-1:0] exp_q[$];
    vec_t vecs[$];

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(.CLK_DIV(CLK_DIV), .DATA_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation ran past its time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        int n;
        logic [1:0] kind;
        logic [W-1:0] act;
        logic [W-1:0] e;
        n = int'(bus.rx_valid) + int'(bus.frame_err) + int'(bus.overrun_err) + int'(bus.parity_err);
        if (n != 0) begin
            checks++;
            if (n > 1) begin
                errors++;
                $display("FAIL pulse_onehot: %0d pulses together at cycle %0d, required 1", n, cyc);
            end
            if (bus.frame_err)        kind = K_FRM;
            else if (bus.parity_err)  kind = K_PAR;
            else if (bus.overrun_err) kind = K_OVR;
            else                      kind = K_VALID;
            if (bus.rx_valid) begin
                prev_valid_cyc = last_valid_cyc;
                last_valid_cyc = cyc;
            end
            act = {kind, bus.rx_data};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: kind %0d data %02h at cycle %0d, required none", kind, bus.rx_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (act !== e)  begin
                    errors++;
                    $display("FAIL pulse_event: kind %0d data %02h, required kind %0d data %02h", act[9:8], act[7:0], e[9:8], e[7:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic drive_bit(input logic b);
        bus.rxd = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic flip);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ flip);
`endif
        drive_bit(stop_bit);
    endtask

    task automatic idle_bits(input int n);
        bus.rxd = 1'b1;
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    task automatic expect_event(input logic [1:0] kind, input logic [7:0] d);
        exp_q.push_back({kind, d});
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic busy_seen;
        checks = 0;
        errors = 0;
        cyc = 0;
        prev_valid_cyc = 0;
        last_valid_cyc = 0;
        last_good = 8'h00;
        reset = 1'b1;
        bus.rxd = 1'b1;
        bus.rx_full = 1'b0;

        vecs.push_back('{8'hA5, 1'b1, 1'b0, 1'b0, K_VALID, 8'hA5});
        vecs.push_back('{8'h5A, 1'b1, 1'b1, 1'b0, K_OVR,   8'hA5});
        vecs.push_back('{8'h3C, 1'b0, 1'b0, 1'b0, K_FRM,   8'hA5});
        vecs.push_back('{8'hC3, 1'b0, 1'b1, 1'b0, K_FRM,   8'hA5});
        vecs.push_back('{8'h81, 1'b1, 1'b0, 1'b0, K_VALID, 8'h81});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b0, K_VALID, 8'h00});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h03, 1'b1, 1'b0, 1'b1, K_PAR,   8'h00});
        vecs.push_back('{8'h03, 1'b0, 1'b0, 1'b1, K_FRM,   8'h00});
        vecs.push_back('{8'h03, 1'b1, 1'b1, 1'b1, K_PAR,   8'h00});
        vecs.push_back('{8'h03, 1'b1, 1'b0, 1'b0, K_VALID, 8'h03});
`endif

        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_rx_data",   32'(bus.rx_data),     32'h00);
        check("reset_rx_valid",  32'(bus.rx_valid),    32'h0);
        check("reset_frame_err", 32'(bus.frame_err),   32'h0);
        check("reset_overrun",   32'(bus.overrun_err), 32'h0);
        check("reset_parity",    32'(bus.parity_err),  32'h0);
        check("reset_busy",      32'(bus.busy),        32'h0);
        check("reset_state",     32'(bus.dbg_state),   32'(ST_IDLE));

        // table-driven frames
        for (int i = 0; i < vecs.size(); i++) begin
            bus.rx_full = vecs[i].full;
            expect_event(vecs[i].kind, vecs[i].exp_data);
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].flip);
            idle_bits(3);
            bus.rx_full = 1'b0;
            check($sformatf("vec%0d_drained", i), 32'(exp_q.size()), 32'd0);
            check($sformatf("vec%0d_busy", i),    32'(bus.busy),     32'd0);
            if (vecs[i].kind == K_VALID) last_good = vecs[i].data;
        end

        // back-to-back frames, single stop bit each
        expect_event(K_VALID, 8'h00);
        expect_event(K_VALID, 8'hFF);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle_bits(3);
        last_good = 8'hFF;
        check("b2b_drained", 32'(exp_q.size()), 32'd0);
        check("b2b_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'(FRAME_BITS * BIT_CLKS));

        // 16-clock low glitch on an idle line
        busy_seen = 1'b0;
        bus.rxd = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 16) bus.rxd = 1'b1;
            @(negedge clk);
            if (i < 39 && bus.busy) busy_seen = 1'b1;
        end
        check("glitch_busy_seen", 32'(busy_seen), 32'd1);
        check("glitch_busy_clear", 32'(bus.busy), 32'd0);
        idle_bits(2);
        check("glitch_no_pulse", 32'(exp_q.size()), 32'd0);

        // framing error followed by a held-low line
        expect_event(K_FRM, last_good);
        send_frame(8'h3C, 1'b0, 1'b0);
        bus.rxd = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("break_state", 32'(bus.dbg_state), 32'(ST_BREAK));
        check("break_busy",  32'(bus.busy),      32'd1);
        idle_bits(1);
        check("break_exit", 32'(bus.dbg_state), 32'(ST_IDLE));
        expect_event(K_VALID, 8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        idle_bits(3);
        last_good = 8'h11;
        check("break_drained", 32'(exp_q.size()), 32'd0);
        check("after_break_data", 32'(bus.rx_data), 32'h11);

        // reset during data bit 4 of 0x77
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h77 >> i));
        bus.rxd = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        last_good = 8'h00;
        idle_bits(3);
        check("abort_rx_data", 32'(bus.rx_data), 32'h00);
        check("abort_busy",    32'(bus.busy),    32'd0);
        check("abort_no_pulse", 32'(exp_q.size()), 32'd0);
        expect_event(K_VALID, 8'h42);
        send_frame(8'h42, 1'b1, 1'b0);
        idle_bits(3);
        check("abort_next_drained", 32'(exp_q.size()), 32'd0);
        check("abort_next_data", 32'(bus.rx_data), 32'h42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
